// File: rtl/sdram_line_reader.sv
// sdram_line_reader: Avalon-MM pipelined master for the SDRAM controller slave.
// Streams LINE_WORDS 16-bit words from a base address into a first-word
// fall-through FIFO for the renderer. When idle it also services single-word
// writes from the game-state logic.
// Optional build macro SDRAM_LINE_READER_STATS_EN adds the stall_cycles and
// max_outstanding statistics outputs.
module sdram_line_reader #(
  parameter int unsigned LINE_WORDS = 640,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned ADDR_W     = 25
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  // Line fetch control
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  // Pixel stream
  output logic [15:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  // Single-word write requests
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [15:0]       wr_data,
  output logic              wr_ack,
`ifdef SDRAM_LINE_READER_STATS_EN
  output logic [15:0]       stall_cycles,
  output logic [4:0]        max_outstanding,
`endif
  // Avalon-MM master
  output logic [ADDR_W-1:0] sdram_address,
  output logic [1:0]        sdram_byteenable_n,
  output logic              sdram_chipselect,
  output logic [15:0]       sdram_writedata,
  output logic              sdram_read_n,
  output logic              sdram_write_n,
  input  logic [15:0]       sdram_readdata,
  input  logic              sdram_readdatavalid,
  input  logic              sdram_waitrequest
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned FcntW = PtrW + 1;
  // Wide enough for LINE_WORDS up to 4095 plus credit arithmetic headroom.
  localparam int unsigned CntW  = 16;

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StWrite} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [15:0]       writedata_q, writedata_d;
  logic              read_n_q, read_n_d;
  logic              write_n_q, write_n_d;
  logic [CntW-1:0]   issue_q, issue_d;
  logic [CntW-1:0]   recv_q, recv_d;

  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [FcntW-1:0]  count_q, count_d;
  logic              push, pop;

  logic              rd_accept, wr_accept, start_ok;
  logic [CntW-1:0]   inflight_d;
  logic              credit;

  // ---------------------------------------------------------------------------
  // Bus-facing outputs come straight from registers
  // ---------------------------------------------------------------------------
  assign sdram_address      = address_q;
  assign sdram_writedata    = writedata_q;
  assign sdram_read_n       = read_n_q;
  assign sdram_write_n      = write_n_q;
  assign sdram_chipselect   = !read_n_q || !write_n_q;
  assign sdram_byteenable_n = 2'b00;
  assign busy               = (state_q != StIdle);

  assign rd_accept = !read_n_q  && !sdram_waitrequest;
  assign wr_accept = !write_n_q && !sdram_waitrequest;
  assign start_ok  = (state_q == StIdle) && start;

  // ---------------------------------------------------------------------------
  // Read FIFO (first-word fall-through)
  // ---------------------------------------------------------------------------
  // Data returning outside a line fetch belongs to nobody and is dropped.
  assign push      = sdram_readdatavalid && ((state_q == StRead) || (state_q == StDrain));
  assign pix_valid = (count_q != '0);
  assign pop       = pix_valid && pix_ready;
  assign pix_data  = mem_q[rd_ptr_q];

  // FIFO occupancy next-state
  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + FcntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - FcntW'(1);
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk_clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sdram_readdata;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_d;
    end
  end

  // Credit guarantees every issued read has a FIFO slot waiting for it.
  assert property (@(posedge clk_clk) disable iff (reset_reset)
                   !(push && !pop && (count_q == FcntW'(FIFO_DEPTH))));

  // ---------------------------------------------------------------------------
  // Issue / receive counters and read credit
  // ---------------------------------------------------------------------------
  // Counter next-state; a new line restarts both counts
  always_comb begin
    issue_d = issue_q;
    recv_d  = recv_q;
    if (start_ok) begin
      issue_d = '0;
      recv_d  = '0;
    end else begin
      if ((state_q == StRead) && rd_accept) issue_d = issue_q + CntW'(1);
      if (push)                             recv_d  = recv_q + CntW'(1);
    end
  end

  // Credit is judged on next-cycle values so that words already popped this
  // cycle free their slot and residual FIFO words from a prior line still count.
  assign inflight_d = (issue_d - recv_d) + CntW'(count_d);
  assign credit     = (inflight_d < CntW'(FIFO_DEPTH));

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  // Next-state, bus command and pulse outputs
  always_comb begin
    state_d     = state_q;
    address_d   = address_q;
    writedata_d = writedata_q;
    read_n_d    = read_n_q;
    write_n_d   = write_n_q;
    done        = 1'b0;
    wr_ack      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // A line fetch wins over a simultaneous write request.
        if (start) begin
          state_d   = StRead;
          address_d = base_addr;
          read_n_d  = !credit;
        end else if (wr_req) begin
          state_d     = StWrite;
          address_d   = wr_addr;
          writedata_d = wr_data;
          write_n_d   = 1'b0;
        end
      end

      StRead: begin
        if (rd_accept) begin
          address_d = address_q + ADDR_W'(1);
        end
        // A command held under waitrequest is never withdrawn; only re-decide
        // once nothing is pending on the bus.
        if (read_n_q || rd_accept) begin
          if (issue_d == CntW'(LINE_WORDS)) begin
            read_n_d = 1'b1;
            state_d  = StDrain;
          end else begin
            read_n_d = !credit;
          end
        end
      end

      StDrain: begin
        if (push && (recv_d == CntW'(LINE_WORDS))) begin
          done    = 1'b1;
          state_d = StIdle;
        end
      end

      StWrite: begin
        if (wr_accept) begin
          wr_ack    = 1'b1;
          write_n_d = 1'b1;
          state_d   = StIdle;
        end
      end

      default: begin
        state_d   = StIdle;
        read_n_d  = 1'b1;
        write_n_d = 1'b1;
      end
    endcase
  end

  // FSM, bus command and counter registers
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= StIdle;
      address_q   <= '0;
      writedata_q <= '0;
      read_n_q    <= 1'b1;
      write_n_q   <= 1'b1;
      issue_q     <= '0;
      recv_q      <= '0;
    end else begin
      state_q     <= state_d;
      address_q   <= address_d;
      writedata_q <= writedata_d;
      read_n_q    <= read_n_d;
      write_n_q   <= write_n_d;
      issue_q     <= issue_d;
      recv_q      <= recv_d;
    end
  end

`ifdef SDRAM_LINE_READER_STATS_EN
  // ---------------------------------------------------------------------------
  // Optional statistics
  // ---------------------------------------------------------------------------
  logic [15:0]     stall_q;
  logic [4:0]      max_out_q;
  logic [CntW-1:0] outstanding;
  logic            cmd_stall;

  assign outstanding     = issue_q - recv_q;
  assign cmd_stall       = (!read_n_q || !write_n_q) && sdram_waitrequest;
  assign stall_cycles    = stall_q;
  assign max_outstanding = max_out_q;

  // Saturating stall counter and outstanding-read high-water mark
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      stall_q   <= '0;
      max_out_q <= '0;
    end else if (start_ok) begin
      stall_q   <= '0;
      max_out_q <= '0;
    end else begin
      if (cmd_stall && (stall_q != 16'hFFFF)) begin
        stall_q <= stall_q + 16'd1;
      end
      if (outstanding > CntW'(max_out_q)) begin
        max_out_q <= outstanding[4:0];
      end
    end
  end
`endif

endmodule
